// File: rtl/pwm_pkg.sv
// Shared constants for the PWM audio path.
//   TPWM_DEF             default PWM period in clocks (must match the mypwm instance)
//   CLKS_PER_SAMPLE_DEF  clocks per audio sample at 100 MHz / 44.1 kHz, rounded
//   dc_width()           width of the duty-cycle bus for a given PWM period (nDC)
//   mid_dc()             midscale duty for a given PWM period (MID_DC)
package pwm_pkg;

  localparam int TPWM_DEF  = 10;
  localparam int CLK_HZ    = 100_000_000;
  localparam int SAMPLE_HZ = 44_100;
  localparam int CLKS_PER_SAMPLE_DEF = (CLK_HZ + SAMPLE_HZ / 2) / SAMPLE_HZ;

  function automatic int dc_width(input int tpwm);
    return $clog2(tpwm + 1);
  endfunction

  function automatic int mid_dc(input int tpwm);
    return tpwm / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
//   clock, resetn   clock and asynchronous active-low reset (empties the FIFO)
//   push_i          write push_data_i; ignored while full, even if a pop happens the same cycle
//   pop_i           drop the head entry; ignored while empty
//   pop_data_o      current head entry (valid while !empty_o)
//   full_o/empty_o  occupancy flags
//   fill_o          number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] fill_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign fill_o     = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid,
  // so resetting the array would only add reset fan-out and block RAM inference.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Feeds signed PCM samples to the mypwm duty-cycle generator.
// Samples arrive on a valid/ready stream, are buffered in a FIFO, and one is popped per
// sample period. Each popped sample is converted to an unsigned duty 0..TPWM-1 through a
// two-stage pipeline, so dc moves two cycles after the popping sample_tick.
//   clock, resetn      clock and asynchronous active-low reset
//   enable             run the sample-rate divider (dc holds and no ticks while low)
//   mute               force midscale duty at the next dc update
//   s_data/s_valid     signed PCM sample stream; s_ready = FIFO not full
//   dc                 registered duty cycle for the PWM DC input
//   sample_tick        one-cycle pulse at each sample-period boundary
//   fill               FIFO occupancy
//   underrun           sticky: a tick found the FIFO empty; clr_underrun clears it
module pwm_sample_feeder
  import pwm_pkg::*;
#(
  parameter int TPWM            = TPWM_DEF,
  parameter int SW              = 16,
  parameter int DEPTH           = 16,
  parameter int CLKS_PER_SAMPLE = CLKS_PER_SAMPLE_DEF
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        mute,
  input  logic [SW-1:0]               s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [dc_width(TPWM)-1:0]   dc,
  output logic                        sample_tick,
  output logic [$clog2(DEPTH+1)-1:0]  fill,
  output logic                        underrun,
  input  logic                        clr_underrun
);

  localparam int NDC = dc_width(TPWM);
  localparam int CW  = $clog2(CLKS_PER_SAMPLE);
  localparam int PW  = SW + NDC;
  localparam logic [NDC-1:0] MID       = NDC'(mid_dc(TPWM));
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [SW-1:0]  SIGN_FLIP = {1'b1, {(SW-1){1'b0}}};

  logic [CW-1:0]  cnt_q, cnt_d;
  logic           s1_valid_q;
  logic [PW-1:0]  s1_prod_q, s1_prod_d;
  logic [NDC-1:0] dc_q, dc_d;
  logic           underrun_q, underrun_d;
  logic [SW-1:0]  head;
  logic           fifo_full, fifo_empty, pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SW)
  ) u_fifo (
    .clock       (clock),
    .resetn      (resetn),
    .push_i      (s_valid),
    .push_data_i (s_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .fill_o      (fill)
  );

  assign s_ready     = !fifo_full;
  assign sample_tick = enable && (cnt_q == CNT_LAST);
  // Pop decision uses the pre-push occupancy: a sample pushed into an empty FIFO on a
  // tick cycle is not played until the following tick.
  assign pop         = sample_tick && !fifo_empty;

  // NOTE: combinational next-state uses blocking assignments with every output given a
  // default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    underrun_d = underrun_q;
    dc_d       = dc_q;
    if (!enable || sample_tick) cnt_d = '0;
    // Set wins over clear when an empty tick and clr_underrun coincide.
    if (sample_tick && fifo_empty) underrun_d = 1'b1;
    else if (clr_underrun)         underrun_d = 1'b0;
    // Offset binary times TPWM; the top NDC bits give floor(u*TPWM/2^SW) <= TPWM-1.
    s1_prod_d = PW'(head ^ SIGN_FLIP) * PW'(TPWM);
    if (s1_valid_q) dc_d = mute ? MID : s1_prod_q[PW-1:SW];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      dc_q       <= MID;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= pop;
      s1_prod_q  <= s1_prod_d;
      dc_q       <= dc_d;
      underrun_q <= underrun_d;
    end
  end

  assign dc       = dc_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Randomized plus directed bench for pwm_sample_feeder (TPWM=10, SW=16, DEPTH=4,
// CLKS_PER_SAMPLE=20). A behavioural model keeps the FIFO as a queue and schedules
// each dc update two edges after its tick; the expected dc is pushed to a scoreboard
// queue that a negedge monitor pops when the DUT's own sample_tick says it is due.
module tb_pwm_sample_feeder;

  localparam int TPWM  = 10;
  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int CPS   = 20;
  localparam int NDC   = 4;
  localparam int FW    = 3;
  localparam int MID   = TPWM / 2;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          mute = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          clr_underrun = 1'b0;
  logic          s_ready, sample_tick, underrun;
  logic [NDC-1:0] dc;
  logic [FW-1:0]  fill;

  always #5 clock = ~clock;

  pwm_sample_feeder #(
    .TPWM            (TPWM),
    .SW              (SW),
    .DEPTH           (DEPTH),
    .CLKS_PER_SAMPLE (CPS)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .enable       (enable),
    .mute         (mute),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dc           (dc),
    .sample_tick  (sample_tick),
    .fill         (fill),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [SW-1:0] s;
    bit          popped;
  } pend_t;

  logic [SW-1:0] m_q[$];
  pend_t         m_pend[$];
  int            m_cnt = 0;
  bit            m_und = 1'b0;
  int            m_dc = MID;
  int            m_edge = 0;
  int            exp_q[$];

  // Signed sample -> duty: map -32768..32767 onto 0..65535, scale to 0..TPWM-1.
  function automatic int conv(input logic [SW-1:0] s);
    return ((int'($signed(s)) + 32768) * TPWM) / 65536;
  endfunction

  always @(posedge clock or negedge resetn) begin
    bit    tick, was_empty, was_full;
    pend_t p;
    if (!resetn) begin
      m_q.delete();
      m_pend.delete();
      m_cnt  = 0;
      m_und  = 1'b0;
      m_dc   = MID;
      m_edge = 0;
    end else begin
      tick      = enable && (m_cnt == CPS - 1);
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      while (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
        p = m_pend.pop_front();
        if (p.popped) m_dc = mute ? MID : conv(p.s);
        exp_q.push_back(m_dc);
      end
      if (tick) begin
        p.due    = m_edge + 1;
        p.popped = !was_empty;
        p.s      = was_empty ? '0 : m_q.pop_front();
        m_pend.push_back(p);
      end
      if (s_valid && !was_full) m_q.push_back(s_data);
      if (tick && was_empty) m_und = 1'b1;
      else if (clr_underrun) m_und = 1'b0;
      m_cnt  = (!enable || tick) ? 0 : m_cnt + 1;
      m_edge = m_edge + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int  errors = 0;
  int  checks = 0;
  int  exp_rd = 0;
  int  neg_n = 0;
  int  due_q[$];
  bit  done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!resetn) begin
      due_q.delete();
      exp_rd = exp_q.size();
      check("reset_fill", 32'(fill), 0);
      check("reset_s_ready", 32'(s_ready), 1);
      check("reset_tick", 32'(sample_tick), 0);
      check("reset_underrun", 32'(underrun), 0);
      check("reset_dc", 32'(dc), MID);
    end else begin
      check("fill", 32'(fill), m_q.size());
      check("s_ready", 32'(s_ready), 32'(m_q.size() < DEPTH));
      check("sample_tick", 32'(sample_tick), 32'(enable && (m_cnt == CPS - 1)));
      check("underrun", 32'(underrun), 32'(m_und));
      check("dc_hold", 32'(dc), m_dc);
      if (sample_tick) due_q.push_back(neg_n + 2);
      while (due_q.size() > 0 && due_q[0] == neg_n) begin
        void'(due_q.pop_front());
        if (exp_rd >= exp_q.size()) begin
          checks++;
          errors++;
          $display("FAIL dc_after_tick: DUT ticked with no expected update at %0t", $time);
        end else begin
          check("dc_after_tick", 32'(dc), exp_q[exp_rd]);
          exp_rd++;
        end
      end
    end
    neg_n++;
    if (done) begin
      check("scoreboard_drained", exp_q.size() - exp_rd, 0);
      check("ticks_drained", due_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [SW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    cyc(1);
    s_valid = 1'b0;
  endtask

  task automatic clear_flag();
    clr_underrun = 1'b1;
    cyc(1);
    clr_underrun = 1'b0;
  endtask

  initial begin
    int rate;
    cyc(3);
    resetn = 1'b1;
    cyc(2);

    // Three reference samples -> 0, 5, 9, then an empty tick.
    push_one(16'h8000);
    push_one(16'h0000);
    push_one(16'h7FFF);
    enable = 1'b1;
    cyc(4 * CPS + 5);
    clear_flag();
    enable = 1'b0;
    cyc(3);

    // Overfill with the divider stopped; the fifth sample waits for the first pop.
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 16'($urandom);
      cyc(1);
    end
    enable = 1'b1;
    cyc(CPS + 3);
    s_valid = 1'b0;
    cyc(5 * CPS + 4);
    clear_flag();
    enable = 1'b0;

    // Mute across one update of a full-scale sample, then release.
    for (int i = 0; i < 3; i++) push_one(16'h7FFF);
    enable = 1'b1;
    mute   = 1'b1;
    cyc(CPS + 3);
    mute   = 1'b0;
    cyc(2 * CPS);
    enable = 1'b0;
    cyc(CPS);

    // Full FIFO with s_valid held across a tick: pop happens, push waits a cycle.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    cyc(6);
    enable = 1'b1;
    cyc(CPS + 2);
    s_valid = 1'b0;

    // Reset mid-playback with samples buffered.
    cyc(CPS / 2);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    cyc(CPS + 5);

    // Random traffic at several push rates.
    for (int seg = 0; seg < 4; seg++) begin
      rate = (seg == 0) ? 2 : (seg == 1) ? 5 : (seg == 2) ? 30 : 80;
      for (int i = 0; i < 400; i++) begin
        s_valid      = ($urandom_range(0, 99) < rate);
        s_data       = 16'($urandom);
        mute         = ($urandom_range(0, 99) < 10);
        enable       = ($urandom_range(0, 99) < 97);
        clr_underrun = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 999) < 3) resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
      end
    end
    s_valid      = 1'b0;
    enable       = 1'b0;
    mute         = 1'b0;
    clr_underrun = 1'b0;
    cyc(6);
    done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
